lsu_split: RTL and testbench
============================

Name: lsu_split

Overview:
- Load/store unit between the single-cycle core's execute stage and port 2 of the data RAM.
- Aligned accesses pass straight through in the same cycle.
- Misaligned halfword and word accesses are split into a sequence of byte accesses, one per clock, with a stall handshake back to the core.
- Loaded bytes are assembled and sign-/zero-extended before they return to the core.

Parameters:
- ALLOW_MISALIGNED, 1, 1 = split misaligned accesses; 0 = raise fault and issue no RAM access.

Ports:
- clk  in  1  system clock; all state on posedge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  core presents a memory operation this cycle
- req_is_store  in  1  1 = store, 0 = load
- req_mode  in  mem_mode  access size/sign (MEM_B, MEM_BU, MEM_H, MEM_HU, MEM_W)
- req_addr  in  cpu_word  byte address
- req_wdata  in  cpu_word  store data, little-endian, low bits significant
- busy  out  1  core must stall and hold its request stable
- rdata  out  cpu_word  extended load result; valid when req_valid & !req_is_store & !busy
- fault  out  1  misaligned access with ALLOW_MISALIGNED=0
- ram_addr  out  cpu_word  to RAM address2
- ram_mode  out  mem_mode  to RAM memMode2
- ram_store  out  1  to RAM port2isStore
- ram_wdata  out  cpu_word  to RAM inw2
- ram_rdata  in  cpu_word  from RAM outw2; combinational read, already byte-extracted per ram_mode

Behaviour:
- Misaligned: MEM_H/HU with addr[0]=1, or MEM_W with addr[1:0]≠0. N = 2 for halfword, 4 for word.
- States are IDLE and STEP. STEP carries idx (2 bits), latched base address, and a 24-bit byte buffer for loads.
- Reset values: state=IDLE, idx=0, buffer=0. While rst is high: ram_store=0, busy=0, fault=0, rdata=0.
- IDLE, no req_valid: ram_store=0, busy=0. ram_addr/ram_mode follow req_addr/req_mode (don't-care).
- IDLE, aligned request (pass-through):
  - ram_addr=req_addr, ram_mode=req_mode, ram_store=req_is_store, ram_wdata=req_wdata.
  - rdata=ram_rdata, busy=0.
  - Latency 0 cycles; a store commits at the next posedge.
- IDLE, misaligned request, ALLOW_MISALIGNED=1:
  - Issue byte 0 this cycle: ram_addr=req_addr, ram_mode=MEM_BU, ram_store=req_is_store, ram_wdata={24'b0, req_wdata[7:0]}.
  - busy=1.
  - At posedge: latch base=req_addr, buffer[7:0]=ram_rdata[7:0], idx←1, state←STEP.
- STEP, idx=k:
  - ram_addr=base+k, wrapping modulo 2^32. ram_mode=MEM_BU. ram_wdata low byte = req_wdata[8k+7:8k]. ram_store=req_is_store.
  - If k<N-1: busy=1; at posedge capture the byte into buffer[8k+7:8k] and set idx←k+1.
  - If k=N-1: busy=0 and rdata = assembled {ram_rdata[7:0], buffer} trimmed to N bytes.
    - MEM_H: sign-extended from bit 15. MEM_HU: zero-extended. MEM_W: no extension.
    - At posedge: state←IDLE, idx←0.
- A misaligned access takes exactly N cycles, with busy high for the first N-1.
- The core must hold every req_* signal stable while busy=1. Base address is latched; the other req_* signals are re-read each step.
- ALLOW_MISALIGNED=0 with a misaligned request:
  - fault=1, busy=0, ram_store=0, rdata=0.
  - State stays IDLE.
- Reset asserted mid-sequence: state returns to IDLE immediately. Bytes already stored remain written; no further bytes are written.
- Back-to-back requests: a new request may be accepted in IDLE on the cycle after the final step. There is no bubble beyond the N cycles.

Decomposition:
- mem_mode enum and cpu_word typedef live in package base. Add the localparams BYTES_H=2 and BYTES_W=4 and a function is_misaligned(mem_mode, logic[1:0]) there.
- One sub-module: lsu_load_assemble, a combinational block that takes the buffer, the final byte, N and mode and produces the extended rdata.

Test Plan:
- Aligned MEM_W load at 0x100, RAM word 0xDEADBEEF -> busy=0 in the same cycle, rdata=0xDEADBEEF, ram_mode=MEM_W, ram_store=0.
- Misaligned MEM_W store 0x11223344 at 0x101 -> 4 cycles, busy=1,1,1,0. RAM byte writes 0x44@0x101, 0x33@0x102, 0x22@0x103, 0x11@0x104; the word read back at 0x104 has low byte 0x11.
- Misaligned MEM_H load at 0x203, bytes 0x80@0x203 and 0xFF@0x204 -> 2 cycles, rdata=0xFFFFFF80. The same access with MEM_HU -> rdata=0x0000FF80.
- Wrap-around: MEM_W load at 0xFFFFFFFF -> byte addresses 0xFFFFFFFF, 0x0, 0x1, 0x2 in successive cycles.
- Reset pulse in cycle 2 of a misaligned word store at 0x301 -> only bytes 0x301 and 0x302 written, state IDLE, busy=0 after reset.
- ALLOW_MISALIGNED=0, MEM_W store at 0x402 -> fault=1, ram_store=0, RAM unchanged, busy=0.

Source files
------------

// File: rtl/base_pkg.sv
// Shared memory-access types for the core datapath and the load/store unit.
package base;

  typedef logic [31:0] cpu_word;

  typedef enum logic [2:0] {
    MEM_B  = 3'd0,
    MEM_BU = 3'd1,
    MEM_H  = 3'd2,
    MEM_HU = 3'd3,
    MEM_W  = 3'd4
  } mem_mode;

  localparam int BYTES_H = 2;
  localparam int BYTES_W = 4;

  function automatic logic is_misaligned(mem_mode mode, logic [1:0] addr_lo);
    case (mode)
      MEM_H, MEM_HU: return addr_lo[0];
      MEM_W:         return addr_lo != 2'b00;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_split_if.sv
// Core-side request/response bundle of the load/store unit.
interface lsu_split_if;
  import base::*;

  logic    req_valid;
  logic    req_is_store;
  mem_mode req_mode;
  cpu_word req_addr;
  cpu_word req_wdata;
  logic    busy;
  cpu_word rdata;
  logic    fault;

  modport master (
    output req_valid, req_is_store, req_mode, req_addr, req_wdata,
    input  busy, rdata, fault
  );

  modport slave (
    input  req_valid, req_is_store, req_mode, req_addr, req_wdata,
    output busy, rdata, fault
  );
endinterface

// File: rtl/lsu_load_assemble.sv
// Joins buffered bytes with the final byte of a split load and extends the result.
module lsu_load_assemble
  import base::*;
(
  input  logic [23:0] buffer,
  input  logic [7:0]  last_byte,
  input  logic [2:0]  nbytes,
  input  mem_mode     mode,
  output cpu_word     rdata
);

  logic [15:0] half;

  always_comb begin
    half  = {last_byte, buffer[7:0]};
    rdata = '0;
    if (nbytes == 3'(BYTES_W))
      rdata = {last_byte, buffer};
    else if (mode == MEM_H)
      rdata = {{16{half[15]}}, half};
    else
      rdata = {16'b0, half};
  end

endmodule

// File: rtl/lsu_split.sv
// Load/store unit: aligned accesses pass through, misaligned ones become one
// byte access per clock with the core stalled until the last byte.
module lsu_split
  import base::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  lsu_split_if.slave  core,
  output cpu_word     ram_addr,
  output mem_mode     ram_mode,
  output logic        ram_store,
  output cpu_word     ram_wdata,
  input  cpu_word     ram_rdata
);

  typedef enum logic {S_IDLE, S_STEP} state_t;

  state_t      state, state_n;
  logic [1:0]  idx, idx_n;
  cpu_word     base_addr;
  logic [23:0] buffer;

  logic        mis, start, last;
  logic [1:0]  last_idx;
  logic [2:0]  nbytes;
  cpu_word     asm_rdata;

  assign mis      = is_misaligned(core.req_mode, core.req_addr[1:0]);
  assign start    = core.req_valid && mis && ALLOW_MISALIGNED;
  assign nbytes   = (core.req_mode == MEM_W) ? 3'(BYTES_W) : 3'(BYTES_H);
  assign last_idx = (core.req_mode == MEM_W) ? 2'd3 : 2'd1;
  assign last     = (idx == last_idx);

  lsu_load_assemble u_asm (
    .buffer    (buffer),
    .last_byte (ram_rdata[7:0]),
    .nbytes    (nbytes),
    .mode      (core.req_mode),
    .rdata     (asm_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= 2'd0;
      base_addr <= '0;
      buffer    <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      if (state == S_IDLE && start) begin
        base_addr    <= core.req_addr;
        buffer[7:0]  <= ram_rdata[7:0];
      end else if (state == S_STEP && !last) begin
        case (idx)
          2'd1:    buffer[15:8]  <= ram_rdata[7:0];
          2'd2:    buffer[23:16] <= ram_rdata[7:0];
          default: buffer[7:0]   <= ram_rdata[7:0];
        endcase
      end
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    case (state)
      S_IDLE: if (start) begin
        state_n = S_STEP;
        idx_n   = 2'd1;
      end
      S_STEP: if (last) begin
        state_n = S_IDLE;
        idx_n   = 2'd0;
      end else begin
        idx_n = idx + 2'd1;
      end
      default: begin
        state_n = S_IDLE;
        idx_n   = 2'd0;
      end
    endcase
  end

  // Address/mode default to the raw request so an idle port still tracks the core.
  always_comb begin
    ram_addr   = core.req_addr;
    ram_mode   = core.req_mode;
    ram_store  = 1'b0;
    ram_wdata  = core.req_wdata;
    core.busy  = 1'b0;
    core.fault = 1'b0;
    core.rdata = '0;
    if (!rst) begin
      case (state)
        S_IDLE: if (core.req_valid) begin
          if (!mis) begin
            ram_store  = core.req_is_store;
            core.rdata = ram_rdata;
          end else if (ALLOW_MISALIGNED) begin
            ram_mode   = MEM_BU;
            ram_store  = core.req_is_store;
            ram_wdata  = {24'b0, core.req_wdata[7:0]};
            core.busy  = 1'b1;
          end else begin
            core.fault = 1'b1;
          end
        end
        S_STEP: begin
          ram_addr  = base_addr + {30'b0, idx};
          ram_mode  = MEM_BU;
          ram_store = core.req_is_store;
          ram_wdata = {24'b0, core.req_wdata[{idx, 3'b000} +: 8]};
          core.busy = !last;
          if (last) core.rdata = asm_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_split.sv
// Randomised scoreboard bench for lsu_split against a byte-array reference model.
module tb_lsu_split;
  import base::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_split_if bus ();
  lsu_split_if bus0 ();

  cpu_word ram_addr, ram_wdata, ram_rdata;
  mem_mode ram_mode;
  logic    ram_store;
  cpu_word ram_addr0, ram_wdata0;
  mem_mode ram_mode0;
  logic    ram_store0;

  lsu_split #(.ALLOW_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst(rst), .core(bus.slave),
    .ram_addr(ram_addr), .ram_mode(ram_mode), .ram_store(ram_store),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  lsu_split #(.ALLOW_MISALIGNED(1'b0)) dut0 (
    .clk(clk), .rst(rst), .core(bus0.slave),
    .ram_addr(ram_addr0), .ram_mode(ram_mode0), .ram_store(ram_store0),
    .ram_wdata(ram_wdata0), .ram_rdata(32'h5A5A_A5A5)
  );

  // ---------------- RAM harness (4 KB, addresses alias modulo 4096)
  logic [7:0]  mem [0:4095];
  logic        bd_we = 1'b0;
  logic [11:0] bd_addr = '0;
  logic [7:0]  bd_data = '0;

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (ram_store) begin
      mem[ram_addr[11:0]] <= ram_wdata[7:0];
      if (ram_mode == MEM_H || ram_mode == MEM_HU || ram_mode == MEM_W)
        mem[ram_addr[11:0] + 12'd1] <= ram_wdata[15:8];
      if (ram_mode == MEM_W) begin
        mem[ram_addr[11:0] + 12'd2] <= ram_wdata[23:16];
        mem[ram_addr[11:0] + 12'd3] <= ram_wdata[31:24];
      end
    end
  end

  logic [7:0] b0, b1, b2, b3;
  always_comb begin
    b0 = mem[ram_addr[11:0]];
    b1 = mem[ram_addr[11:0] + 12'd1];
    b2 = mem[ram_addr[11:0] + 12'd2];
    b3 = mem[ram_addr[11:0] + 12'd3];
    case (ram_mode)
      MEM_B:   ram_rdata = {{24{b0[7]}}, b0};
      MEM_BU:  ram_rdata = {24'b0, b0};
      MEM_H:   ram_rdata = {{16{b1[7]}}, b1, b0};
      MEM_HU:  ram_rdata = {16'b0, b1, b0};
      default: ram_rdata = {b3, b2, b1, b0};
    endcase
  end

  // ---------------- reference model and scoreboard
  logic [7:0] model [0:4095];

  typedef struct {
    bit      is_store;
    mem_mode mode;
    cpu_word base;
    bit      mis;
    int      cycles;
    cpu_word rdata;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int size_of(mem_mode m);
    case (m)
      MEM_H, MEM_HU: return 2;
      MEM_W:         return 4;
      default:       return 1;
    endcase
  endfunction

  // Architectural view: a store writes nb little-endian bytes, a load reads and extends them.
  task automatic model_access(bit st, mem_mode m, cpu_word a, cpu_word d, output cpu_word v);
    int nb = size_of(m);
    v = '0;
    for (int i = 0; i < nb; i++) begin
      cpu_word ai = a + cpu_word'(i);
      if (st) model[ai[11:0]] = d[8*i +: 8];
      else    v = v | (cpu_word'(model[ai[11:0]]) << (8*i));
    end
    if (!st && (m == MEM_B || m == MEM_H) && v[8*nb-1])
      for (int i = 8*nb; i < 32; i++) v[i] = 1'b1;
  endtask

  task automatic bd_write(logic [11:0] a, logic [7:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    model[a] = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic issue(bit st, mem_mode m, cpu_word a, cpu_word d);
    exp_t e;
    cpu_word v;
    bit done = 1'b0;
    model_access(st, m, a, d, v);
    e.is_store = st; e.mode = m; e.base = a;
    e.mis = (a % cpu_word'(size_of(m))) != 0;
    e.cycles = e.mis ? size_of(m) : 1;
    e.rdata = v;
    sb.push_back(e);
    bus.req_valid = 1'b1; bus.req_is_store = st; bus.req_mode = m;
    bus.req_addr = a; bus.req_wdata = d;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      if (!bus.busy) done = 1'b1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL busy_timeout: busy still 1 after 10 cycles at addr %h", a);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  // Monitor: checks every RAM-side step and the completed response against the queue.
  initial begin
    int cyc = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst || !mon_en) cyc = 0;
      else if (bus.req_valid) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_empty: unexpected request at addr %h", bus.req_addr);
        end else begin
          e = sb[0];
          chk("ram_addr", ram_addr, e.mis ? e.base + cpu_word'(cyc) : e.base);
          chk("ram_mode", 32'(ram_mode), e.mis ? 32'(MEM_BU) : 32'(e.mode));
          chk("ram_store", 32'(ram_store), 32'(e.is_store));
          cyc++;
          if (!bus.busy) begin
            void'(sb.pop_front());
            chk("cycles", 32'(cyc), 32'(e.cycles));
            chk("fault", 32'(bus.fault), 32'd0);
            if (!e.is_store) chk("rdata", bus.rdata, e.rdata);
            cyc = 0;
          end
        end
      end
    end
  end

  // ---------------- stimulus
  initial begin
    cpu_word v;
    int bad;
    mem_mode modes [5] = '{MEM_B, MEM_BU, MEM_H, MEM_HU, MEM_W};

    rst = 1'b1;
    bus.req_valid = 1'b1; bus.req_is_store = 1'b1; bus.req_mode = MEM_W;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h1234_5678;
    bus0.req_valid = 1'b0; bus0.req_is_store = 1'b0; bus0.req_mode = MEM_W;
    bus0.req_addr = '0; bus0.req_wdata = '0;
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_store", 32'(ram_store), 32'd0);
    chk("rst_fault", 32'(bus.fault), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 4096; i++) bd_write(12'(i), 8'($urandom));
    mon_en = 1'b1;

    // Directed cases
    bd_write(12'h100, 8'hEF); bd_write(12'h101, 8'hBE);
    bd_write(12'h102, 8'hAD); bd_write(12'h103, 8'hDE);
    issue(1'b0, MEM_W, 32'h100, 32'h0);
    issue(1'b1, MEM_W, 32'h101, 32'h1122_3344);
    issue(1'b0, MEM_W, 32'h104, 32'h0);
    bd_write(12'h203, 8'h80); bd_write(12'h204, 8'hFF);
    issue(1'b0, MEM_H, 32'h203, 32'h0);
    issue(1'b0, MEM_HU, 32'h203, 32'h0);
    issue(1'b0, MEM_W, 32'hFFFF_FFFF, 32'h0);
    issue(1'b1, MEM_H, 32'hFFFF_FFFF, 32'hBEEF_CAFE);
    issue(1'b0, MEM_H, 32'hFFFF_FFFF, 32'h0);

    // Reset in the middle of a split store: only the first two bytes land
    mon_en = 1'b0;
    bus.req_valid = 1'b1; bus.req_is_store = 1'b1; bus.req_mode = MEM_W;
    bus.req_addr = 32'h301; bus.req_wdata = 32'hAABB_CCDD;
    @(negedge clk);
    chk("mid_busy0", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_addr1", ram_addr, 32'h302);
    @(posedge clk); #1;
    rst = 1'b1; bus.req_valid = 1'b0;
    model[12'h301] = 8'hDD; model[12'h302] = 8'hCC;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
    chk("mem_303_untouched", 32'(mem[12'h303]), 32'(model[12'h303]));
    mon_en = 1'b1;
    issue(1'b0, MEM_W, 32'h300, 32'h0);

    // Random traffic, back-to-back
    for (int n = 0; n < 200; n++)
      issue(1'($urandom), modes[$urandom_range(4, 0)], $urandom, $urandom);

    // Fault path on the non-splitting variant
    bus0.req_valid = 1'b1; bus0.req_is_store = 1'b1; bus0.req_mode = MEM_W;
    bus0.req_addr = 32'h402; bus0.req_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("f_fault", 32'(bus0.fault), 32'd1);
    chk("f_store", 32'(ram_store0), 32'd0);
    chk("f_busy", 32'(bus0.busy), 32'd0);
    chk("f_rdata", bus0.rdata, 32'd0);
    @(posedge clk); #1;
    bus0.req_is_store = 1'b0; bus0.req_mode = MEM_HU; bus0.req_addr = 32'h405;
    @(negedge clk);
    chk("f_fault_h", 32'(bus0.fault), 32'd1);
    @(posedge clk); #1;
    bus0.req_is_store = 1'b1; bus0.req_mode = MEM_W; bus0.req_addr = 32'h400;
    @(negedge clk);
    chk("f_aligned_fault", 32'(bus0.fault), 32'd0);
    chk("f_aligned_store", 32'(ram_store0), 32'd1);
    chk("f_aligned_busy", 32'(bus0.busy), 32'd0);
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;

    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    bad = 0;
    for (int i = 0; i < 4096; i++)
      if (mem[i] !== model[i]) begin
        if (bad == 0) $display("FAIL mem_image: addr %h got %h expected %h", i, mem[i], model[i]);
        bad++;
      end
    checks++;
    if (bad != 0) errors++;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
